msrh_mp_fifo: RTL and testbench
===============================

Name: msrh_mp_fifo

Overview:
Parametrised multi-port in-order FIFO. It accepts up to ENQ_PORTS entries per cycle and presents up to DEQ_PORTS oldest entries per cycle. It is the generic buffer behind dispatch-width structures: the dispatch/commit queues (DISP_SIZE wide) and the LDQ/STQ allocation staging. It generalises fixed-size queues to arbitrary width, depth (including non-power-of-two) and port counts, and adds flush plus a partial-dequeue count.

Parameters:
WIDTH, 32, payload bits per entry
DEPTH, 8, number of entries; any value >= max(ENQ_PORTS, DEQ_PORTS); need not be a power of two
ENQ_PORTS, 2, enqueue lanes per cycle (default matches DISP_SIZE)
DEQ_PORTS, 2, dequeue lanes per cycle
CNT_W, $clog2(DEPTH+1), width of the occupancy count (derived)

Ports:
i_clk  in  1  clock; all state updates on the rising edge
i_reset  in  1  synchronous, active-high reset
i_flush  in  1  discard all contents (e.g. pipeline flush)
i_enq_valid  in  ENQ_PORTS  per-lane enqueue request; must be low-packed (contiguous from bit 0)
i_enq_data  in  ENQ_PORTS*WIDTH  lane k occupies bits [k*WIDTH +: WIDTH]
o_enq_ready  out  1  high when free entries >= ENQ_PORTS
o_deq_valid  out  DEQ_PORTS  lane k valid when count > k
o_deq_data  out  DEQ_PORTS*WIDTH  lane k = k-th oldest entry
i_deq_num  in  $clog2(DEQ_PORTS+1)  number of entries consumed this cycle
o_count  out  CNT_W  current occupancy
o_empty  out  1  count == 0
o_full  out  1  count == DEPTH

Behaviour:
- Reset (synchronous, active-high, has priority over everything): rd_ptr=0, wr_ptr=0, count=0; o_empty=1, o_full=0, o_enq_ready=1, o_deq_valid=0. Storage array is not reset; o_deq_data is don't-care while the matching valid bit is low.
- Enqueue:
  - Fires when o_enq_ready && |i_enq_valid; n_enq = popcount(i_enq_valid).
  - Lane k is written to (wr_ptr+k) mod DEPTH.
  - wr_ptr advances by n_enq mod DEPTH.
  - When o_enq_ready is low, all enqueue lanes are ignored; the upstream block holds its data.
- o_enq_ready is registered-state only: (DEPTH - count) >= ENQ_PORTS. It does not depend on same-cycle dequeue, so there is no comb path from i_deq_num to o_enq_ready.
- Dequeue:
  - o_deq_valid[k] = (count > k).
  - o_deq_data lane k is read combinationally from (rd_ptr+k) mod DEPTH.
  - i_deq_num entries are consumed at the edge; rd_ptr advances by i_deq_num mod DEPTH.
- Latency: an entry written at edge N is visible on o_deq_* in the cycle after edge N. There is no bypass from enqueue to dequeue in the same cycle.
- Simultaneous enqueue and dequeue: both apply; count_next = count + n_enq - i_deq_num.
  - Full with ENQ_PORTS<=DEQ_PORTS: dequeue proceeds but enqueue is still blocked that cycle (ready is conservative).
- Wrap-around: pointer addition uses a wrap-aware add. If sum >= DEPTH, subtract DEPTH. Correct for non-power-of-two DEPTH; never use bit truncation.
- Flush: i_flush=1 at edge N sets rd_ptr=wr_ptr=0 and count=0. Enqueue and dequeue in that cycle are discarded. Reset beats flush.
- Protocol violations, checked by simulation assertions only (not by RTL):
  - i_deq_num > count.
  - Non-contiguous i_enq_valid.
  - Enqueue attempted with i_reset high.
- Invariants: count never exceeds DEPTH; o_full and o_enq_ready are never both 1 when ENQ_PORTS>=1.

Decomposition:
- msrh_conf_pkg: add DISP_SIZE-derived defaults and a CMT_DEQ_SIZE localparam, used by instantiating blocks.
- msrh_pkg: add a generic function/typedef for low-packed valid checking, for shared assertions.
- One sub-module: msrh_wrap_ptr_add (parameters DEPTH and ADD_W; pointer + increment mod DEPTH, combinational). Instantiate it once for wr_ptr, once for rd_ptr, and per read lane.

Test Plan:
1. Reset and basic pass-through (WIDTH=8, DEPTH=6, ENQ=DEQ=2): enq_valid=2'b11 with data {0xB2,0xA1} -> next cycle deq_valid=2'b11, lane0=0xA1, lane1=0xB2, count=2.
2. Fill to the ready threshold: three 2-lane enqueues with no dequeue -> count=6, o_full=1, o_enq_ready=0. A further enqueue of 0xFF is dropped; count stays 6.
3. Non-power-of-two wrap: fill to 6, deq_num=2 for 2 cycles, enqueue {0x11,0x22} -> entries occupy indices 0,1 after wrap. Oldest-first order holds: lane0 shows the 5th entry, and 0x11/0x22 appear last.
4. Simultaneous operations at count=4: enqueue 2, deq_num=1 -> count=5. Next cycle: enqueue 1 lane is blocked (free=1 < 2) while deq_num=2 -> count=3.
5. Flush mid-operation: count=5 with i_flush and enqueue of 2 entries -> next cycle count=0, o_empty=1, deq_valid=0, rd_ptr=wr_ptr=0.
6. Reset mid-operation with i_reset=1, i_flush=1 and enqueue active -> all outputs at reset values. The first enqueue after reset appears on lane0.

Source files
------------

// File: rtl/msrh_mp_fifo_pkg.sv
// Shared constants and helpers for the multi-port FIFO and its users.
package msrh_mp_fifo_pkg;

    // Dispatch width; sizes the default enqueue/dequeue lane counts.
    localparam int unsigned DISP_SIZE         = 2;
    localparam int unsigned CMT_DEQ_SIZE      = DISP_SIZE;
    localparam int unsigned MP_FIFO_WIDTH_DEF = 32;
    localparam int unsigned MP_FIFO_DEPTH_DEF = 8;

    typedef logic [31:0] valid_vec_t;

    // True when the set bits form one contiguous run starting at bit 0 (or none are set).
    function automatic logic is_low_packed(input valid_vec_t v);
        return ((v + valid_vec_t'(1)) & v) == '0;
    endfunction

endpackage

// File: rtl/msrh_mp_fifo_if.sv
// Handshake bundle between the FIFO (slave) and its producer/consumer (master).
interface msrh_mp_fifo_if #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 8,
    parameter int unsigned ENQ_PORTS = 2,
    parameter int unsigned DEQ_PORTS = 2
);
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
    localparam int unsigned DEQ_NUM_W = $clog2(DEQ_PORTS + 1);

    logic [ENQ_PORTS-1:0]       i_enq_valid;
    logic [ENQ_PORTS*WIDTH-1:0] i_enq_data;
    logic                       o_enq_ready;
    logic [DEQ_PORTS-1:0]       o_deq_valid;
    logic [DEQ_PORTS*WIDTH-1:0] o_deq_data;
    logic [DEQ_NUM_W-1:0]       i_deq_num;
    logic [CNT_W-1:0]           o_count;
    logic                       o_empty;
    logic                       o_full;

    modport slave (
        input  i_enq_valid, i_enq_data, i_deq_num,
        output o_enq_ready, o_deq_valid, o_deq_data, o_count, o_empty, o_full
    );

    modport master (
        output i_enq_valid, i_enq_data, i_deq_num,
        input  o_enq_ready, o_deq_valid, o_deq_data, o_count, o_empty, o_full
    );

endinterface

// File: rtl/msrh_wrap_ptr_add.sv
// Combinational (ptr + inc) mod DEPTH for any DEPTH; inc must not exceed DEPTH.
module msrh_wrap_ptr_add #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ADD_W = 2,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic [PTR_W-1:0] ptr,
    input  logic [ADD_W-1:0] inc,
    output logic [PTR_W-1:0] result
);
    localparam int unsigned SUM_W = ((PTR_W > ADD_W) ? PTR_W : ADD_W) + 1;

    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] wrapped;

    // One conditional subtract wraps correctly even for non-power-of-two depths.
    always_comb begin
        sum     = SUM_W'(ptr) + SUM_W'(inc);
        wrapped = (sum >= SUM_W'(DEPTH)) ? (sum - SUM_W'(DEPTH)) : sum;
        result  = PTR_W'(wrapped);
    end

endmodule

// File: rtl/msrh_mp_fifo.sv
// Multi-port in-order FIFO: up to ENQ_PORTS writes and DEQ_PORTS oldest reads per cycle.
module msrh_mp_fifo
    import msrh_mp_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = MP_FIFO_WIDTH_DEF,
    parameter int unsigned DEPTH     = MP_FIFO_DEPTH_DEF,
    parameter int unsigned ENQ_PORTS = DISP_SIZE,
    parameter int unsigned DEQ_PORTS = CMT_DEQ_SIZE
) (
    input logic           i_clk,
    input logic           i_reset,
    input logic           i_flush,
    msrh_mp_fifo_if.slave fifo
);
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned ENQ_CNT_W = $clog2(ENQ_PORTS + 1);
    localparam int unsigned DEQ_NUM_W = $clog2(DEQ_PORTS + 1);

    logic [WIDTH-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic [PTR_W-1:0]     wr_addr [ENQ_PORTS];
    logic [PTR_W-1:0]     rd_addr [DEQ_PORTS];
    logic [CNT_W-1:0]     free_cnt;
    logic                 enq_ready, enq_fire;
    logic [ENQ_CNT_W-1:0] n_enq, n_enq_eff;

    // Readiness looks only at registered occupancy, keeping deq_num off the ready path.
    always_comb begin
        free_cnt  = CNT_W'(DEPTH) - count_q;
        enq_ready = free_cnt >= CNT_W'(ENQ_PORTS);
        n_enq     = '0;
        for (int k = 0; k < ENQ_PORTS; k++) begin
            n_enq = n_enq + ENQ_CNT_W'(fifo.i_enq_valid[k]);
        end
        enq_fire  = enq_ready && (|fifo.i_enq_valid);
        n_enq_eff = enq_fire ? n_enq : '0;
        count_d   = count_q + CNT_W'(n_enq_eff) - CNT_W'(fifo.i_deq_num);
    end

    msrh_wrap_ptr_add #(.DEPTH(DEPTH), .ADD_W(ENQ_CNT_W)) u_wr_ptr_add (
        .ptr    (wr_ptr_q),
        .inc    (n_enq_eff),
        .result (wr_ptr_d)
    );

    msrh_wrap_ptr_add #(.DEPTH(DEPTH), .ADD_W(DEQ_NUM_W)) u_rd_ptr_add (
        .ptr    (rd_ptr_q),
        .inc    (fifo.i_deq_num),
        .result (rd_ptr_d)
    );

    for (genvar k = 0; k < ENQ_PORTS; k++) begin : g_wr_addr
        msrh_wrap_ptr_add #(.DEPTH(DEPTH), .ADD_W(ENQ_CNT_W)) u_add (
            .ptr    (wr_ptr_q),
            .inc    (ENQ_CNT_W'(k)),
            .result (wr_addr[k])
        );
    end

    for (genvar k = 0; k < DEQ_PORTS; k++) begin : g_rd_addr
        msrh_wrap_ptr_add #(.DEPTH(DEPTH), .ADD_W(DEQ_NUM_W)) u_add (
            .ptr    (rd_ptr_q),
            .inc    (DEQ_NUM_W'(k)),
            .result (rd_addr[k])
        );
    end

    // Pointer/occupancy state; reset beats flush, both clear everything.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents are never cleared, validity comes from count_q.
    always_ff @(posedge i_clk) begin
        if (!i_reset && !i_flush && enq_fire) begin
            for (int k = 0; k < ENQ_PORTS; k++) begin
                if (fifo.i_enq_valid[k]) begin
                    mem_q[wr_addr[k]] <= fifo.i_enq_data[k*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Output lanes present the oldest entries straight from storage.
    always_comb begin
        fifo.o_deq_data  = '0;
        fifo.o_deq_valid = '0;
        for (int k = 0; k < DEQ_PORTS; k++) begin
            fifo.o_deq_valid[k]              = count_q > CNT_W'(k);
            fifo.o_deq_data[k*WIDTH +: WIDTH] = mem_q[rd_addr[k]];
        end
        fifo.o_enq_ready = enq_ready;
        fifo.o_count     = count_q;
        fifo.o_empty     = count_q == '0;
        fifo.o_full      = count_q == CNT_W'(DEPTH);
    end

    // Protocol and invariant checks; simulation only, no effect on the datapath.
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            assert (CNT_W'(fifo.i_deq_num) <= count_q)
            else $error("deq_num exceeds occupancy");
            assert (is_low_packed(valid_vec_t'(fifo.i_enq_valid)))
            else $error("enq_valid not low-packed");
            assert (count_q <= CNT_W'(DEPTH))
            else $error("occupancy above depth");
            assert (!(fifo.o_full && enq_ready))
            else $error("full and ready both set");
        end else begin
            assert (fifo.i_enq_valid == '0)
            else $warning("enqueue request ignored while reset is asserted");
        end
    end

endmodule

// File: tb/tb_msrh_mp_fifo.sv
// Directed bench for msrh_mp_fifo at WIDTH=8, DEPTH=6, two enqueue and two dequeue lanes.
module tb_msrh_mp_fifo;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 6;
    localparam int unsigned ENQ   = 2;
    localparam int unsigned DEQ   = 2;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    int   checks = 0;
    int   errors = 0;

    msrh_mp_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ENQ_PORTS(ENQ), .DEQ_PORTS(DEQ)) fifo_if ();

    msrh_mp_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ENQ_PORTS(ENQ), .DEQ_PORTS(DEQ)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_flush (flush),
        .fifo    (fifo_if)
    );

    always #5 clk = ~clk;

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [15:0] d, input logic [1:0] n);
        fifo_if.i_enq_valid = v;
        fifo_if.i_enq_data  = d;
        fifo_if.i_deq_num   = n;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        flush = 1'b0;
        drive(2'b00, 16'h0000, 2'd0);
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (fifo_if.o_count !== 3'd0) begin errors++;
            $display("FAIL reset_count: got %0d expected 0", fifo_if.o_count); end
        checks++; if (fifo_if.o_empty !== 1'b1) begin errors++;
            $display("FAIL reset_empty: got %b expected 1", fifo_if.o_empty); end
        checks++; if (fifo_if.o_full !== 1'b0) begin errors++;
            $display("FAIL reset_full: got %b expected 0", fifo_if.o_full); end
        checks++; if (fifo_if.o_enq_ready !== 1'b1) begin errors++;
            $display("FAIL reset_ready: got %b expected 1", fifo_if.o_enq_ready); end
        checks++; if (fifo_if.o_deq_valid !== 2'b00) begin errors++;
            $display("FAIL reset_deq_valid: got %b expected 00", fifo_if.o_deq_valid); end
    endtask

    task automatic test_pass_through();
        drive(2'b11, {8'hB2, 8'hA1}, 2'd0);
        step();
        drive(2'b00, 16'h0000, 2'd0);
        checks++; if (fifo_if.o_deq_valid !== 2'b11) begin errors++;
            $display("FAIL pass_valid: got %b expected 11", fifo_if.o_deq_valid); end
        checks++; if (fifo_if.o_deq_data[7:0] !== 8'hA1) begin errors++;
            $display("FAIL pass_lane0: got %h expected a1", fifo_if.o_deq_data[7:0]); end
        checks++; if (fifo_if.o_deq_data[15:8] !== 8'hB2) begin errors++;
            $display("FAIL pass_lane1: got %h expected b2", fifo_if.o_deq_data[15:8]); end
        checks++; if (fifo_if.o_count !== 3'd2) begin errors++;
            $display("FAIL pass_count: got %0d expected 2", fifo_if.o_count); end
        drive(2'b00, 16'h0000, 2'd2);
        step();
        drive(2'b00, 16'h0000, 2'd0);
        checks++; if (fifo_if.o_empty !== 1'b1) begin errors++;
            $display("FAIL pass_drain_empty: got %b expected 1", fifo_if.o_empty); end
    endtask

    // Pointers start at 2 here, so the fill itself wraps through index 0.
    task automatic test_fill();
        drive(2'b11, {8'h02, 8'h01}, 2'd0); step();
        drive(2'b11, {8'h04, 8'h03}, 2'd0); step();
        checks++; if (fifo_if.o_enq_ready !== 1'b1) begin errors++;
            $display("FAIL fill_ready_at4: got %b expected 1", fifo_if.o_enq_ready); end
        drive(2'b11, {8'h06, 8'h05}, 2'd0); step();
        checks++; if (fifo_if.o_count !== 3'd6) begin errors++;
            $display("FAIL fill_count: got %0d expected 6", fifo_if.o_count); end
        checks++; if (fifo_if.o_full !== 1'b1) begin errors++;
            $display("FAIL fill_full: got %b expected 1", fifo_if.o_full); end
        checks++; if (fifo_if.o_enq_ready !== 1'b0) begin errors++;
            $display("FAIL fill_ready: got %b expected 0", fifo_if.o_enq_ready); end
        drive(2'b11, {8'hFF, 8'hFF}, 2'd0); step();
        drive(2'b00, 16'h0000, 2'd0);
        checks++; if (fifo_if.o_count !== 3'd6) begin errors++;
            $display("FAIL fill_drop_count: got %0d expected 6", fifo_if.o_count); end
        checks++; if (fifo_if.o_deq_data !== {8'h02, 8'h01}) begin errors++;
            $display("FAIL fill_oldest: got %h expected 0201", fifo_if.o_deq_data); end
    endtask

    task automatic test_wrap();
        apply_reset();
        drive(2'b11, {8'h02, 8'h01}, 2'd0); step();
        drive(2'b11, {8'h04, 8'h03}, 2'd0); step();
        drive(2'b11, {8'h06, 8'h05}, 2'd0); step();
        drive(2'b00, 16'h0000, 2'd2); step();
        step();
        drive(2'b11, {8'h22, 8'h11}, 2'd0); step();
        drive(2'b00, 16'h0000, 2'd0);
        checks++; if (fifo_if.o_count !== 3'd4) begin errors++;
            $display("FAIL wrap_count: got %0d expected 4", fifo_if.o_count); end
        checks++; if (fifo_if.o_deq_data !== {8'h06, 8'h05}) begin errors++;
            $display("FAIL wrap_oldest: got %h expected 0605", fifo_if.o_deq_data); end
        checks++; if (dut.wr_ptr_q !== 3'd2) begin errors++;
            $display("FAIL wrap_wr_ptr: got %0d expected 2", dut.wr_ptr_q); end
        drive(2'b00, 16'h0000, 2'd2); step();
        drive(2'b00, 16'h0000, 2'd0);
        checks++; if (fifo_if.o_deq_data !== {8'h22, 8'h11}) begin errors++;
            $display("FAIL wrap_newest: got %h expected 2211", fifo_if.o_deq_data); end
        checks++; if (dut.rd_ptr_q !== 3'd0) begin errors++;
            $display("FAIL wrap_rd_ptr: got %0d expected 0", dut.rd_ptr_q); end
    endtask

    // Starts with 11,22 queued (count 2).
    task automatic test_simultaneous();
        drive(2'b11, {8'h34, 8'h33}, 2'd0); step();
        checks++; if (fifo_if.o_count !== 3'd4) begin errors++;
            $display("FAIL sim_count4: got %0d expected 4", fifo_if.o_count); end
        drive(2'b11, {8'h36, 8'h35}, 2'd1); step();
        checks++; if (fifo_if.o_count !== 3'd5) begin errors++;
            $display("FAIL sim_count5: got %0d expected 5", fifo_if.o_count); end
        checks++; if (fifo_if.o_deq_data !== {8'h33, 8'h22}) begin errors++;
            $display("FAIL sim_order5: got %h expected 3322", fifo_if.o_deq_data); end
        checks++; if (fifo_if.o_enq_ready !== 1'b0) begin errors++;
            $display("FAIL sim_ready5: got %b expected 0", fifo_if.o_enq_ready); end
        drive(2'b01, {8'h00, 8'h77}, 2'd2); step();
        drive(2'b00, 16'h0000, 2'd0);
        checks++; if (fifo_if.o_count !== 3'd3) begin errors++;
            $display("FAIL sim_count3: got %0d expected 3", fifo_if.o_count); end
        checks++; if (fifo_if.o_deq_data !== {8'h35, 8'h34}) begin errors++;
            $display("FAIL sim_order3: got %h expected 3534", fifo_if.o_deq_data); end
        checks++; if (fifo_if.o_enq_ready !== 1'b1) begin errors++;
            $display("FAIL sim_ready3: got %b expected 1", fifo_if.o_enq_ready); end
    endtask

    task automatic test_flush();
        drive(2'b11, {8'h38, 8'h37}, 2'd0); step();
        checks++; if (fifo_if.o_count !== 3'd5) begin errors++;
            $display("FAIL flush_pre_count: got %0d expected 5", fifo_if.o_count); end
        flush = 1'b1;
        drive(2'b11, {8'hAA, 8'hBB}, 2'd1); step();
        flush = 1'b0;
        drive(2'b00, 16'h0000, 2'd0);
        checks++; if (fifo_if.o_count !== 3'd0) begin errors++;
            $display("FAIL flush_count: got %0d expected 0", fifo_if.o_count); end
        checks++; if (fifo_if.o_empty !== 1'b1) begin errors++;
            $display("FAIL flush_empty: got %b expected 1", fifo_if.o_empty); end
        checks++; if (fifo_if.o_deq_valid !== 2'b00) begin errors++;
            $display("FAIL flush_valid: got %b expected 00", fifo_if.o_deq_valid); end
        checks++; if (dut.rd_ptr_q !== 3'd0 || dut.wr_ptr_q !== 3'd0) begin errors++;
            $display("FAIL flush_ptrs: got rd=%0d wr=%0d expected 0/0", dut.rd_ptr_q, dut.wr_ptr_q); end
        drive(2'b11, {8'hC2, 8'hC1}, 2'd0); step();
        drive(2'b00, 16'h0000, 2'd0);
        checks++; if (fifo_if.o_deq_data !== {8'hC2, 8'hC1}) begin errors++;
            $display("FAIL flush_refill: got %h expected c2c1", fifo_if.o_deq_data); end
    endtask

    task automatic test_reset_mid();
        reset = 1'b1;
        flush = 1'b1;
        drive(2'b11, {8'hDD, 8'hEE}, 2'd1); step();
        reset = 1'b0;
        flush = 1'b0;
        drive(2'b00, 16'h0000, 2'd0);
        checks++; if (fifo_if.o_count !== 3'd0 || fifo_if.o_empty !== 1'b1) begin errors++;
            $display("FAIL rst_mid_count: got %0d/%b expected 0/1", fifo_if.o_count, fifo_if.o_empty); end
        checks++; if (fifo_if.o_full !== 1'b0 || fifo_if.o_enq_ready !== 1'b1) begin errors++;
            $display("FAIL rst_mid_flags: got full=%b ready=%b expected 0/1", fifo_if.o_full,
                     fifo_if.o_enq_ready); end
        checks++; if (fifo_if.o_deq_valid !== 2'b00) begin errors++;
            $display("FAIL rst_mid_valid: got %b expected 00", fifo_if.o_deq_valid); end
        drive(2'b01, {8'h00, 8'h5A}, 2'd0); step();
        drive(2'b00, 16'h0000, 2'd0);
        checks++; if (fifo_if.o_deq_valid !== 2'b01 || fifo_if.o_deq_data[7:0] !== 8'h5A) begin
            errors++;
            $display("FAIL rst_mid_first: got valid=%b lane0=%h expected 01/5a",
                     fifo_if.o_deq_valid, fifo_if.o_deq_data[7:0]); end
        checks++; if (fifo_if.o_count !== 3'd1) begin errors++;
            $display("FAIL rst_mid_count1: got %0d expected 1", fifo_if.o_count); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        drive(2'b00, 16'h0000, 2'd0);
        test_reset();
        test_pass_through();
        test_fill();
        test_wrap();
        test_simultaneous();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
